// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the serial adder controller
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice; never below 1 bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_adder_hs.sv
// rtl/full_adder_hs.sv - 1-bit full adder built from two half adders
module full_adder_hs (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // Both half-adder carries can never be high together, so OR gives the majority function.
    assign c = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - 1-bit half adder primitive
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencing one shared full adder
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    inc_carry;
    logic             last_bit;

    logic             fa_s;
    logic             fa_c;

    // The single arithmetic stage: every sum bit passes through this instance.
    full_adder_hs u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    assign last_bit = (cnt == LAST);

    // Counter increment as an explicit XOR/AND ripple so no adder is inferred outside the stage.
    always_comb begin
        inc_carry    = '0;
        cnt_inc      = '0;
        inc_carry[0] = 1'b1;
        for (int i = 1; i < CW; i++) begin
            inc_carry[i] = inc_carry[i-1] & cnt[i-1];
        end
        for (int i = 0; i < CW; i++) begin
            cnt_inc[i] = cnt[i] ^ inc_carry[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs; done and busy are pure functions of state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accepted start, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt_inc;
                    if (last_bit) begin
                        sum  <= {fa_s, res_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
